brpred_unit: RTL

//  Parametrised branch prediction and resolution unit for the pipelined core.
//  IF side: direct-mapped BTB with saturating counters gives a predicted next PC.
//  EX side: resolves B/JAL/JALR from comparator flags, flags mispredicts, gives the redirect PC.

---
 rtl/brpred_unit.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/brpred_unit.sv
// Branch prediction and resolution unit.
// Fetch side: direct-mapped BTB with saturating direction counters, 0-cycle lookup.
// Execute side: resolves B/JAL/JALR, flags mispredicts, supplies the redirect PC,
// trains the BTB on the following rising edge and keeps saturating statistics.
module brpred_unit #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [XLEN-1:0]   if_pc_i,
    output logic              if_pred_taken_o,
    output logic [XLEN-1:0]   if_pred_target_o,
    input  logic              ex_valid_i,
    input  logic [31:0]       ex_inst_i,
    input  logic [XLEN-1:0]   ex_pc_i,
    input  logic [XLEN-1:0]   ex_target_i,
    input  logic              ex_pred_taken_i,
    input  logic [XLEN-1:0]   ex_pred_target_i,
    input  logic              br_less_i,
    input  logic              br_equal_i,
    output logic              ex_taken_o,
    output logic              ex_mispredict_o,
    output logic [XLEN-1:0]   ex_redirect_pc_o,
    output logic [STAT_W-1:0] stat_branch_o,
    output logic [STAT_W-1:0] stat_miss_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TH  = CNT_W'(2 ** (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(2 ** (CNT_W - 1) - 1);
    localparam logic [XLEN-1:0]  PC_INC  = XLEN'(32'd4);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Counter increment that sticks at the strongly-taken value.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Counter decrement that sticks at the strongly-not-taken value.
    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b0}}) ? c : c - {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Statistics increment that holds at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] s);
        return (&s) ? s : s + {{(STAT_W-1){1'b0}}, 1'b1};
    endfunction

    logic             valid_r [ENTRIES];
    logic [CNT_W-1:0] cnt_r   [ENTRIES];
    logic [TAG_W-1:0] tag_r   [ENTRIES];
    logic [XLEN-1:0]  tgt_r   [ENTRIES];
    logic [STAT_W-1:0] stat_branch_r;
    logic [STAT_W-1:0] stat_miss_r;

    logic [IDX_W-1:0] if_idx_s;
    logic [TAG_W-1:0] if_tag_s;
    logic             if_hit_s;
    logic [IDX_W-1:0] ex_idx_s;
    logic [TAG_W-1:0] ex_tag_s;
    logic             ex_hit_s;
    logic             is_b_s;
    logic             is_j_s;
    logic             b_fn_ok_s;
    logic             b_cond_s;
    logic             ctl_s;
    logic             taken_s;
    logic             mispredict_s;
    logic             upd_en_s;
    logic [CNT_W-1:0] upd_cnt_s;
    logic [XLEN-1:0]  upd_tgt_s;
    logic             unused_bits_s;

    assign if_idx_s = if_pc_i[IDX_W+1:2];
    assign if_tag_s = if_pc_i[XLEN-1:IDX_W+2];
    assign ex_idx_s = ex_pc_i[IDX_W+1:2];
    assign ex_tag_s = ex_pc_i[XLEN-1:IDX_W+2];
    assign unused_bits_s = ^{if_pc_i[1:0], ex_pc_i[1:0], ex_inst_i[31:15], ex_inst_i[11:7]};

    // Fetch-side lookup; always sees the table as it was before this cycle's training write.
    always_comb begin
        if_hit_s         = valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s);
        if_pred_taken_o  = if_hit_s && (cnt_r[if_idx_s] >= CNT_TH);
        if (if_pred_taken_o) begin
            if_pred_target_o = tgt_r[if_idx_s];
        end else begin
            if_pred_target_o = if_pc_i + PC_INC;
        end
    end

    // Decode and branch condition; funct3 010/011 are not branches and are ignored entirely.
    always_comb begin
        is_b_s    = (ex_inst_i[6:0] == OP_BRANCH);
        is_j_s    = (ex_inst_i[6:0] == OP_JAL) || (ex_inst_i[6:0] == OP_JALR);
        b_fn_ok_s = 1'b1;
        b_cond_s  = 1'b0;
        case (ex_inst_i[14:12])
            3'b000:         b_cond_s = br_equal_i;
            3'b001:         b_cond_s = !br_equal_i;
            3'b100, 3'b110: b_cond_s = br_less_i;
            3'b101, 3'b111: b_cond_s = !br_less_i;
            default: begin
                b_fn_ok_s = 1'b0;
                b_cond_s  = 1'b0;
            end
        endcase
    end

    // Resolution: actual direction, mispredict detection and the correct next PC.
    always_comb begin
        ctl_s        = ex_valid_i && (is_j_s || (is_b_s && b_fn_ok_s));
        taken_s      = ctl_s && (is_j_s || b_cond_s);
        mispredict_s = ctl_s && ((ex_pred_taken_i != taken_s) ||
                                 (taken_s && (ex_pred_target_i != ex_target_i)));
        ex_hit_s     = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s);
        if (taken_s) begin
            ex_redirect_pc_o = ex_target_i;
        end else begin
            ex_redirect_pc_o = ex_pc_i + PC_INC;
        end
    end

    assign ex_taken_o      = taken_s;
    assign ex_mispredict_o = mispredict_s;
    assign stat_branch_o   = stat_branch_r;
    assign stat_miss_o     = stat_miss_r;

    // Training decision: which entry value gets written at the next edge, if any.
    always_comb begin
        upd_en_s  = 1'b0;
        upd_cnt_s = cnt_r[ex_idx_s];
        upd_tgt_s = ex_target_i;
        if (ctl_s) begin
            if (is_j_s) begin
                upd_en_s  = 1'b1;
                upd_cnt_s = CNT_MAX;
            end else if (taken_s) begin
                upd_en_s  = 1'b1;
                upd_cnt_s = ex_hit_s ? cnt_inc(cnt_r[ex_idx_s]) : CNT_TH;
            end else if (ex_hit_s) begin
                // Not-taken on a hit only weakens the counter; target stays.
                upd_en_s  = 1'b1;
                upd_cnt_s = cnt_dec(cnt_r[ex_idx_s]);
                upd_tgt_s = tgt_r[ex_idx_s];
            end else begin
                upd_en_s  = 1'b0;
            end
        end else begin
            upd_en_s = 1'b0;
        end
    end

    // BTB storage: cleared asynchronously, written by the training decision.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
                cnt_r[i]   <= CNT_WNT;
                tag_r[i]   <= {TAG_W{1'b0}};
                tgt_r[i]   <= {XLEN{1'b0}};
            end
        end else if (upd_en_s) begin
            valid_r[ex_idx_s] <= 1'b1;
            cnt_r[ex_idx_s]   <= upd_cnt_s;
            tag_r[ex_idx_s]   <= ex_tag_s;
            tgt_r[ex_idx_s]   <= upd_tgt_s;
        end
    end

    // Saturating statistics over resolved control transfers and mispredicts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_branch_r <= {STAT_W{1'b0}};
            stat_miss_r   <= {STAT_W{1'b0}};
        end else begin
            if (ctl_s) begin
                stat_branch_r <= stat_inc(stat_branch_r);
            end
            if (mispredict_s) begin
                stat_miss_r <= stat_inc(stat_miss_r);
            end
        end
    end

endmodule
